mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, memory address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 Parameter LOCK_MAX, default 4, max consecutive locked grants to one requester while the other is requesting (range 1..15).
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 reqN (N=0,1)  input  1  access request from requester N (0 = cpu, 1 = loader/DMA).
REQ-007 lockN  input  1  requester N asks to keep the bus on its next request.
REQ-008 weN  input  1  1 = write, 0 = read.
REQ-009 addrN  input  ADDR_W  access address.
REQ-010 wdataN  input  DATA_W  write data.
REQ-011 gntN  output  1  access of requester N issued this cycle.
REQ-012 rvalidN  output  1  one-cycle pulse, rdataN valid.
REQ-013 rdataN  output  DATA_W  registered read data for requester N.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_addr  output  ADDR_W  memory address.
REQ-016 mem_wdata  output  DATA_W  memory write data.
REQ-017 mem_rdata  input  DATA_W  memory read data, combinational from mem_addr.

Function
REQ-018 At most one of gnt0/gnt1 SHALL be high per cycle; gntN SHALL be high only when reqN is high.
REQ-019 gntN is combinational from reqN/lockN and registered state; the granted access executes in the same cycle.
REQ-020 Requesters hold reqN, weN, addrN, wdataN stable until the cycle gntN is high; the arbiter SHALL NOT buffer requests.
REQ-021 Memory outputs SHALL mux from the granted requester; with no grant: mem_we=0, mem_addr=0, mem_wdata=0.
REQ-022 FSM state = owner of previous cycle: IDLE (no grant), OWN0, OWN1; next state = OWNN if gntN, else IDLE.
REQ-023 Register last (1 bit) = last granted requester, updated on every grant.
REQ-024 Only one requester active: it SHALL be granted.
REQ-025 Both active, no lock in force: requester != last SHALL be granted (round-robin).
REQ-026 Lock in force when state=OWNN, lockN was high in that grant cycle (registered), reqN high now, and lock_cnt < LOCK_MAX: N SHALL be granted regardless of the other request.
REQ-027 lock_cnt (4 bits) SHALL increment on each locked re-grant with the other requester pending, clear on handoff, on an IDLE cycle, or on a grant with lockN=0; SHALL never exceed LOCK_MAX.
REQ-028 lock_cnt = LOCK_MAX and other requester pending: other requester SHALL be granted.
REQ-029 Lock with the other requester idle: N SHALL keep being granted, lock_cnt unchanged.
REQ-030 Read grant (weN=0): rdataN SHALL capture mem_rdata at that edge; rvalidN SHALL pulse high the following cycle only.
REQ-031 Write grant: no rvalid; rdataN unchanged.
REQ-032 rdataN SHALL hold its value until the next read for port N.
REQ-033 Back-to-back reads by one port SHALL give back-to-back rvalid pulses, one per grant, in order.

Reset
REQ-034 With rst_n low, immediately: state=IDLE, last=1, lock_cnt=0, rvalid0=rvalid1=0, rdata0=rdata1=0, registered lock flag=0.
REQ-035 While rst_n low, gnt0=gnt1=0 and mem_we=0 regardless of requests.
REQ-036 Reset mid-read: pending rvalid SHALL be dropped, no pulse after release.
REQ-037 First cycle after release with both requesting: requester 0 SHALL be granted.

Verification
REQ-038 Reset, req0 read addr 5 (mem[5]=16'h00A5), req1=0 -> gnt0 same cycle, next cycle rvalid0=1, rdata0=16'h00A5.
REQ-039 req0 and req1 held continuously, lock=0 -> grants alternate 0,1,0,1; never both high.
REQ-040 LOCK_MAX=4, req0+lock0 held, req1 held -> gnt0 5 consecutive cycles (1 initial + 4 locked), then gnt1 once.
REQ-041 req1 write addr 3 data 16'h1234, then req0 read addr 3 -> mem_we=1 only in write cycle, rdata0=16'h1234, no rvalid1.
REQ-042 rst_n low in cycle after a read grant to port 1 -> rvalid1 never pulses, rdata1=0, gnt low during reset.
REQ-043 lock1 held, req0 idle -> gnt1 every cycle indefinitely, lock_cnt stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: combinational grant, round-robin between the ports,
// bounded bus locking, and a registered read-data path with a one-cycle rvalid pulse.
module mem_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              lock0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              lock1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              lock_q, lock_d;
  logic [3:0]        lock_cnt_q, lock_cnt_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              force0, force1;

  // Grant decision: a lock still within budget beats round-robin.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    force0 = (state_q == OWN0) && lock_q && req0 && (lock_cnt_q < LOCK_MAX_C);
    force1 = (state_q == OWN1) && lock_q && req1 && (lock_cnt_q < LOCK_MAX_C);
    if (!rst_n) begin
      gnt0 = 1'b0;
    end else if (force0) begin
      gnt0 = 1'b1;
    end else if (force1) begin
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
      gnt0 = last_q;
      gnt1 = !last_q;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  always_comb begin
    state_d    = IDLE;
    last_d     = last_q;
    lock_d     = 1'b0;
    lock_cnt_d = '0;
    rvalid0_d  = gnt0 && !we0;
    rvalid1_d  = gnt1 && !we1;
    rdata0_d   = rvalid0_d ? mem_rdata : rdata0_q;
    rdata1_d   = rvalid1_d ? mem_rdata : rdata1_q;
    if (gnt0) begin
      state_d = OWN0;
      last_d  = 1'b0;
      lock_d  = lock0;
      // Streak only advances while the other side is actually being held off.
      if (lock0 && state_q == OWN0)
        lock_cnt_d = (force0 && req1) ? lock_cnt_q + 4'd1 : lock_cnt_q;
    end else if (gnt1) begin
      state_d = OWN1;
      last_d  = 1'b1;
      lock_d  = lock1;
      if (lock1 && state_q == OWN1)
        lock_cnt_d = (force1 && req0) ? lock_cnt_q + 4'd1 : lock_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: read-data registers are reset as well, since their contents are visible at the ports.
      state_q    <= IDLE;
      last_q     <= 1'b1;
      lock_q     <= 1'b0;
      lock_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      last_q     <= last_d;
      lock_q     <= lock_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level model predicts grants and
// memory traffic, queues expected read returns, and a monitor matches them against rvalid/rdata.
module tb_mem_arbiter;

  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 16;
  localparam int LOCK_MAX = 4;

  typedef struct {
    int                port;
    logic [DATA_W-1:0] data;
    int                due;
  } rd_t;

  logic clk;
  logic rst_n;
  logic              r_req[2], r_lock[2], r_we[2];
  logic [ADDR_W-1:0] r_addr[2];
  logic [DATA_W-1:0] r_wdata[2];
  logic gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [DATA_W-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  logic [DATA_W-1:0] mem[2**ADDR_W];
  logic [DATA_W-1:0] ref_mem[2**ADDR_W];

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  bit  mon_en  = 0;
  rd_t exp_q[$];
  logic [DATA_W-1:0] exp_rdata[2];

  // Model state: who held the bus last cycle, whether it asked to keep it,
  // how many locked grants it has taken while the other port waited, and the last winner.
  int m_owner;
  bit m_locked;
  int m_streak;
  int m_last;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(r_req[0]), .lock0(r_lock[0]), .we0(r_we[0]), .addr0(r_addr[0]), .wdata0(r_wdata[0]),
    .req1(r_req[1]), .lock1(r_lock[1]), .we1(r_we[1]), .addr1(r_addr[1]), .wdata1(r_wdata[1]),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc++;
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_locked = 0;
    m_streak = 0;
    m_last   = 1;
    exp_q.delete();
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  function automatic bit lock_on();
    return m_owner >= 0 && m_locked && r_req[m_owner] && m_streak < LOCK_MAX;
  endfunction

  function automatic int pick();
    if (!rst_n) return -1;
    if (lock_on()) return m_owner;
    if (r_req[0] && r_req[1]) return 1 - m_last;
    if (r_req[0]) return 0;
    if (r_req[1]) return 1;
    return -1;
  endfunction

  // Monitor: at most one grant per cycle, so at most one read return is due per cycle.
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      bit due_now;
      int port;
      due_now = exp_q.size() > 0 && exp_q[0].due == cyc;
      port    = due_now ? exp_q[0].port : -1;
      check("rvalid0", rvalid0, port == 0);
      check("rvalid1", rvalid1, port == 1);
      if (due_now) begin
        exp_rdata[port] = exp_q[0].data;
        void'(exp_q.pop_front());
      end
      check("rdata0", rdata0, exp_rdata[0]);
      check("rdata1", rdata1, exp_rdata[1]);
    end
  end

  // One bus cycle: check grant and memory outputs mid-cycle, update the model, end just after the edge.
  task automatic step(input bit rst_after, output int g);
    bit forced;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    @(negedge clk);
    g       = pick();
    forced  = lock_on();
    e_we    = 1'b0;
    e_addr  = '0;
    e_wdata = '0;
    if (g >= 0) begin
      e_we    = r_we[g];
      e_addr  = r_addr[g];
      e_wdata = r_wdata[g];
    end
    check("gnt0", gnt0, g == 0);
    check("gnt1", gnt1, g == 1);
    check("mem_we", mem_we, e_we);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    if (g < 0) begin
      m_owner  = -1;
      m_locked = 0;
      m_streak = 0;
    end else begin
      if (r_we[g]) ref_mem[r_addr[g]] = r_wdata[g];
      else exp_q.push_back('{port: g, data: ref_mem[r_addr[g]], due: cyc + 1});
      if (!r_lock[g] || g != m_owner) m_streak = 0;
      else if (forced && r_req[1-g]) m_streak++;
      m_owner  = g;
      m_locked = r_lock[g];
      m_last   = g;
    end
    if (rst_after) begin
      rst_n = 0;
      model_reset();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input bit req, input bit lock, input bit we,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    r_req[p]   = req;
    r_lock[p]  = lock;
    r_we[p]    = we;
    r_addr[p]  = addr;
    r_wdata[p] = wdata;
  endtask

  initial begin
    int g;
    int run0;
    logic [DATA_W-1:0] v;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      v = DATA_W'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[5] = 16'h00A5;
    ref_mem[5] = 16'h00A5;
    model_reset();

    // Reset with both ports requesting writes: nothing may be granted or written.
    rst_n = 0;
    set_req(0, 1, 0, 1, 6'd9, 16'hDEAD);
    set_req(1, 1, 0, 1, 6'd9, 16'hBEEF);
    @(posedge clk);
    mon_en = 1;
    @(negedge clk);
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_mem_we", mem_we, 0);
    @(posedge clk);
    #1;
    set_req(0, 1, 0, 0, 6'd5, 16'h0);
    set_req(1, 0, 0, 0, 6'd0, 16'h0);
    rst_n = 1;

    // Single read of address 5 by port 0.
    step(0, g);
    check("first_read_gnt", g, 0);
    set_req(0, 0, 0, 0, 6'd0, 16'h0);
    step(0, g);

    // Both ports continuously reading, no lock: strict alternation.
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1, 0, 0, 6'(i), 16'h0);
      set_req(1, 1, 0, 0, 6'(i + 20), 16'h0);
      step(0, g);
    end
    set_req(0, 0, 0, 0, 6'd0, 16'h0);
    set_req(1, 0, 0, 0, 6'd0, 16'h0);
    step(0, g);

    // Port 0 takes the bus with lock, port 1 then waits: 1 + LOCK_MAX grants, then handoff.
    set_req(0, 1, 1, 0, 6'd11, 16'h0);
    step(0, g);
    run0 = (g == 0) ? 1 : 0;
    set_req(1, 1, 0, 0, 6'd12, 16'h0);
    for (int i = 0; i < 20; i++) begin
      step(0, g);
      if (g != 0) break;
      run0++;
    end
    check("lock_run_len", run0, LOCK_MAX + 1);
    set_req(0, 0, 0, 0, 6'd0, 16'h0);
    set_req(1, 0, 0, 0, 6'd0, 16'h0);
    step(0, g);

    // Write by port 1 followed by a read of the same address by port 0.
    set_req(1, 1, 0, 1, 6'd3, 16'h1234);
    step(0, g);
    set_req(1, 0, 0, 0, 6'd0, 16'h0);
    set_req(0, 1, 0, 0, 6'd3, 16'h0);
    step(0, g);
    set_req(0, 0, 0, 0, 6'd0, 16'h0);
    step(0, g);

    // Port 1 locked with port 0 idle keeps the bus; once port 0 shows up the lock budget applies.
    set_req(1, 1, 1, 0, 6'd40, 16'h0);
    for (int i = 0; i < 10; i++) step(0, g);
    set_req(0, 1, 0, 0, 6'd41, 16'h0);
    for (int i = 0; i < 7; i++) step(0, g);
    set_req(0, 0, 0, 0, 6'd0, 16'h0);
    set_req(1, 0, 0, 0, 6'd0, 16'h0);
    step(0, g);

    // Reset right after a read grant to port 1: the return must never appear.
    set_req(1, 1, 0, 0, 6'd7, 16'h0);
    step(1, g);
    set_req(0, 1, 0, 0, 6'd8, 16'h0);
    check("rst_mid_gnt0", gnt0, 0);
    check("rst_mid_gnt1", gnt1, 0);
    check("rst_mid_rvalid1", rvalid1, 0);
    check("rst_mid_rdata1", rdata1, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    step(0, g);
    check("post_rst_winner", g, 0);
    set_req(0, 0, 0, 0, 6'd0, 16'h0);
    set_req(1, 1, 0, 0, 6'd7, 16'h0);
    step(0, g);
    set_req(1, 0, 0, 0, 6'd0, 16'h0);

    // Random traffic: each requester holds a transaction until the model says it was granted.
    for (int n = 0; n < 500; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!r_req[p]) begin
          if ($urandom_range(3) != 0)
            set_req(p, 1, $urandom_range(2) == 0, $urandom_range(1) == 1,
                    ADDR_W'($urandom), DATA_W'($urandom));
          else
            set_req(p, 0, 0, 0, '0, '0);
        end
      end
      step(0, g);
      if (g >= 0) r_req[g] = 0;
    end

    set_req(0, 0, 0, 0, 6'd0, 16'h0);
    set_req(1, 0, 0, 0, 6'd0, 16'h0);
    step(0, g);
    step(0, g);
    check("returns_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
